// File: rtl/bin2bcd_seq_if.sv
// Source-select, operand and result bundle between the calculator core and the
// BCD converter; master drives the operands and start, slave returns status.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
);
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic signed [WIDTH-1:0] data_in;
  logic                    err_in;
  logic [1:0]              sel;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [4*DIGITS-1:0]     digits;
  logic                    neg;
  logic                    nan;

  modport master (
    output a, b, data_in, err_in, sel, start,
    input  busy, done, digits, neg, nan
  );

  modport slave (
    input  a, b, data_in, err_in, sel, start,
    output busy, done, digits, neg, nan
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Signed binary to BCD by double-dabble, one bit per clock; done WIDTH+1 cycles after start.
// start is ignored while busy (never queued); outputs hold until the next done.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  function automatic logic [63:0] max_val(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAXVAL = max_val(DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                  state;
  logic [WIDTH-1:0]        mag;
  logic [BW-1:0]           bcd;
  logic [BW-1:0]           bcd_adj;
  logic [CW-1:0]           cnt;
  logic                    lamp;
  logic                    sign;
  logic                    ovf;
  logic signed [WIDTH-1:0] src;
  logic [WIDTH-1:0]        src_mag;
  logic                    busy_q;
  logic                    done_q;
  logic [BW-1:0]           digits_q;
  logic                    neg_q;
  logic                    nan_q;

  always_comb begin
    src = '0;
    unique case (bus.sel)
      2'd0:    src = bus.a;
      2'd2:    src = bus.b;
      2'd3:    src = bus.data_in;
      default: src = '0;
    endcase
    // Unsigned WIDTH bits hold |most-negative| exactly.
    src_mag = src[WIDTH-1] ? WIDTH'(-src) : WIDTH'(src);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      lamp     <= 1'b0;
      sign     <= 1'b0;
      ovf      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= '0;
      neg_q    <= 1'b0;
      nan_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          busy_q <= bus.start;
          if (bus.start) begin
            lamp  <= (bus.sel == 2'd1);
            sign  <= src[WIDTH-1];
            mag   <= src_mag;
            ovf   <= (64'(src_mag) > MAXVAL) || (bus.err_in && bus.sel == 2'd3);
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          // Digits above DIGITS fall off the top; such values are flagged by ovf.
          bcd <= {bcd_adj[BW-2:0], mag[WIDTH-1]};
          mag <= mag << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
          if (lamp) begin
            digits_q <= {DIGITS{4'd8}};
            neg_q    <= 1'b0;
            nan_q    <= 1'b0;
          end else if (ovf) begin
            digits_q <= '0;
            neg_q    <= sign;
            nan_q    <= 1'b1;
          end else begin
            digits_q <= bcd;
            neg_q    <= sign;
            nan_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.digits = digits_q;
  assign bus.neg    = neg_q;
  assign bus.nan    = nan_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Random and directed stimulus for bin2bcd_seq, checked every cycle against a
// decimal-arithmetic reference model with cycle-count timing.
module tb_bin2bcd_seq;
  localparam int W = 16;
  localparam int D = 4;

  typedef struct packed {
    logic [4*D-1:0] dig;
    logic           neg;
    logic           nan;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();
  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain decimal arithmetic on the selected value.
  function automatic res_t expect_of(input logic [1:0] s, input logic signed [W-1:0] v,
                                     input logic e);
    res_t   r;
    longint val;
    longint mag;
    longint maxv;
    r    = '0;
    maxv = 1;
    for (int i = 0; i < D; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    if (s == 2'd1) begin
      r.dig = {D{4'd8}};
      return r;
    end
    val   = longint'(v);
    mag   = (val < 0) ? -val : val;
    r.neg = (val < 0);
    if (mag > maxv || (e && s == 2'd3)) begin
      r.nan = 1'b1;
    end else begin
      for (int i = 0; i < D; i++) begin
        r.dig[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
    end
    return r;
  endfunction

  function automatic logic signed [W-1:0] pick(input logic [1:0] s);
    case (s)
      2'd0:    return bus.a;
      2'd2:    return bus.b;
      2'd3:    return bus.data_in;
      default: return '0;
    endcase
  endfunction

  // Timing model: accept in idle, result W+1 edges later, idle again on the next edge.
  int   m_phase;
  logic m_busy;
  logic m_done;
  res_t m_res;
  res_t p_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_res   <= '0;
      p_res   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_phase == 0) begin
        m_busy <= bus.start;
        if (bus.start) begin
          p_res   <= expect_of(bus.sel, pick(bus.sel), bus.err_in);
          m_phase <= 1;
        end
      end else if (m_phase == W + 1) begin
        m_done  <= 1'b1;
        m_res   <= p_res;
        m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cycle{busy,done,neg,nan,digits}",
          {bus.busy, bus.done, bus.neg, bus.nan, bus.digits},
          {m_busy, m_done, m_res.neg, m_res.nan, m_res.dig});
  end

  function automatic logic signed [W-1:0] rnd_val();
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom_range(0, 9999));
      1: v = int'($urandom);
      2: begin
        case ($urandom_range(0, 6))
          0: v = 9999;
          1: v = 10000;
          2: v = -9999;
          3: v = -10000;
          4: v = 0;
          5: v = -32768;
          default: v = 32767;
        endcase
      end
      default: v = int'($urandom_range(0, 99));
    endcase
    if ($urandom_range(0, 1) == 1 && v > 0 && v < 10001) v = -v;
    return W'(v);
  endfunction

  task automatic run_conv(input logic [1:0] s, input logic signed [W-1:0] v, input logic e,
                          output int lat);
    @(negedge clk);
    bus.a       = rnd_val();
    bus.b       = rnd_val();
    bus.data_in = rnd_val();
    case (s)
      2'd0:    bus.a = v;
      2'd2:    bus.b = v;
      2'd3:    bus.data_in = v;
      default: ;
    endcase
    bus.sel    = s;
    bus.err_in = e;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check("done_seen", (lat > 0), 1);
  endtask

  task automatic after_done();
    @(posedge clk);
    #1 check("busy_low_after_done", {bus.busy, bus.done}, 2'b00);
  endtask

  initial begin
    int lat;
    int ndone;
    int d1;
    int d2;
    bus.a = '0; bus.b = '0; bus.data_in = '0;
    bus.err_in = 1'b0; bus.sel = 2'd0; bus.start = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", {bus.busy, bus.done, bus.neg, bus.nan, bus.digits}, 20'h0);

    run_conv(2'd0, 16'sd1234, 1'b0, lat);
    check("latency", lat, 17);
    check("a1234", {bus.neg, bus.nan, bus.digits}, {2'b00, 16'h1234});
    after_done();

    run_conv(2'd2, -16'sd567, 1'b0, lat);
    check("b_neg567", {bus.neg, bus.nan, bus.digits}, {2'b10, 16'h0567});
    after_done();
    run_conv(2'd2, 16'sd0, 1'b0, lat);
    check("b_zero", {bus.neg, bus.nan, bus.digits}, {2'b00, 16'h0000});
    after_done();

    run_conv(2'd3, 16'sd9999, 1'b0, lat);
    check("d9999", {bus.neg, bus.nan, bus.digits}, {2'b00, 16'h9999});
    after_done();
    run_conv(2'd3, 16'sd10000, 1'b0, lat);
    check("d10000_nan", {bus.neg, bus.nan, bus.digits}, {2'b01, 16'h0000});
    after_done();
    run_conv(2'd3, 16'h8000, 1'b0, lat);
    check("dmin_nan", {bus.neg, bus.nan, bus.digits}, {2'b11, 16'h0000});
    after_done();

    run_conv(2'd3, 16'sd42, 1'b1, lat);
    check("err_nan", {bus.neg, bus.nan, bus.digits}, {2'b01, 16'h0000});
    after_done();
    run_conv(2'd1, rnd_val(), 1'b1, lat);
    check("lamp", {bus.neg, bus.nan, bus.digits}, {2'b00, 16'h8888});
    after_done();

    // Second start and operand change while converting must not disturb the result.
    @(negedge clk);
    bus.sel = 2'd0; bus.a = 16'sd321; bus.err_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.a = 16'sd999; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 if (bus.done) ndone++;
    end
    check("one_done_midconv", ndone, 1);
    check("captured_321", bus.digits, 16'h0321);

    // Held start re-triggers every W+2 cycles.
    @(negedge clk);
    bus.sel = 2'd0; bus.a = 16'sd77; bus.start = 1'b1;
    ndone = 0; d1 = -1; d2 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    bus.start = 1'b0;
    check("held_done_count", ndone, 2);
    check("held_spacing", d2 - d1, 18);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1 if (!bus.busy) begin
        lat = i;
        break;
      end
    end
    check("drain_idle", (lat >= 0), 1);
    check("held_0077", bus.digits, 16'h0077);

    // Reset during iteration 8 clears outputs immediately and suppresses done.
    @(negedge clk);
    bus.sel = 2'd0; bus.a = 16'sd1234; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", {bus.busy, bus.done, bus.neg, bus.nan, bus.digits}, 20'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (bus.done) ndone++;
    end
    check("no_done_after_abort", ndone, 0);
    run_conv(2'd0, 16'sd1, 1'b0, lat);
    check("a1_after_reset", {bus.neg, bus.nan, bus.digits}, {2'b00, 16'h0001});
    after_done();

    // Random traffic: inputs change every cycle, starts arrive at random.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.a       = rnd_val();
      bus.b       = rnd_val();
      bus.data_in = rnd_val();
      bus.sel     = 2'($urandom_range(0, 3));
      bus.err_in  = 1'($urandom_range(0, 1));
      bus.start   = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised signed-binary-to-BCD converter for the calculator display path. It selects one of four sources (operand A, operand B, lamp-test pattern, ALU result) and converts the magnitude to DIGITS BCD digits by iterative double-dabble, one bit per clock. It reports sign and out-of-range ("NaN") status and hands results to the seven-segment driver through a start/busy/done handshake. Outputs hold until the next completed conversion.

## Interface
- WIDTH, 16: bit width of signed inputs; legal 4..32.
- DIGITS, 4: BCD digits produced; legal 1..9; MAXVAL = 10^DIGITS − 1.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- a  in  WIDTH  signed operand A (sel=0).
- b  in  WIDTH  signed operand B (sel=2).
- data_in  in  WIDTH  signed ALU result (sel=3).
- err_in  in  1  ALU error flag, meaningful only with sel=3.
- sel  in  2  source select: 0=a, 1=lamp test, 2=b, 3=data_in.
- start  in  1  request conversion; sampled only in IDLE.
- busy  out  1  high in CONV and DONE.
- done  out  1  one-cycle pulse; outputs valid from this cycle.
- digits  out  4*DIGITS  BCD, digit 0 in bits [3:0].
- neg  out  1  captured value negative.
- nan  out  1  magnitude > MAXVAL, or err_in with sel=3.

## Operation
- States: IDLE, CONV, DONE. rst → IDLE from any state.
- IDLE: on start=1, capture sel, selected value, and err_in; latch sign; compute magnitude = |value| in WIDTH unsigned bits, so the most-negative value is represented exactly; clear BCD accumulator and iteration counter; go to CONV.
- CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, mag} left by one. After exactly WIDTH iterations, go to DONE.
- DONE: update output registers, assert done, return to IDLE next cycle.
- Output update at DONE:
  - sel=1: digits = all 4'd8; neg=0; nan=0.
  - nan condition (magnitude > MAXVAL, or captured err_in with sel=3): nan=1; digits all 0; neg = captured sign.
  - otherwise: digits = accumulator; neg = captured sign; nan=0.
- Overflow uses the captured magnitude compared against MAXVAL. Accumulator bits beyond 4*DIGITS are discarded.
- Zero converts with neg=0. Negative zero is impossible in two's complement.
- start while busy is ignored, not queued. Input changes after capture do not affect the conversion in flight.

## Timing
- Reset values: busy=0, done=0, digits=0, neg=0, nan=0, state IDLE.
- start sampled high at edge k (IDLE) → busy=1 from k.
- CONV occupies edges k+1..k+WIDTH.
- done=1 and new outputs visible during the cycle after edge k+WIDTH+1. Latency is WIDTH+1 cycles from start to done; busy falls one cycle after done.
- A start held high re-triggers on the first IDLE cycle after DONE. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- rst mid-conversion aborts immediately: no done pulse, outputs return to reset values.
- digits, neg, and nan change only at reset or at DONE, never mid-conversion.

## Test plan
Scenarios use WIDTH=16, DIGITS=4.
- a=1234, sel=0, start pulse → done exactly 17 cycles later; digits=1,2,3,4; neg=0; nan=0; busy low one cycle after done.
- b=−567, sel=2 → digits=0,5,6,7; neg=1; nan=0. Then b=0 → digits=0,0,0,0; neg=0.
- data_in=9999 → digits=9,9,9,9; nan=0. Then data_in=10000 → nan=1, digits=0. Then data_in=−32768 → nan=1, neg=1.
- sel=3, data_in=42, err_in=1 → nan=1, digits=0. Then sel=1 with any inputs → digits=8,8,8,8; neg=0; nan=0.
- Second start pulse mid-CONV and a-value changed mid-CONV → exactly one done, carrying the originally captured value. Start held high for 40 cycles → done pulses spaced 18 cycles apart.
- rst asserted at CONV iteration 8 → all outputs 0 asynchronously, no done. Then a fresh conversion of a=1 → digits=0,0,0,1.
